uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line bit rate.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port data  output  8  received byte; valid only while valid=1.
REQ-007 Port valid  output  1  byte available; held until accepted.
REQ-008 Port require  input  1  consumer ready; byte transfers on a cycle with valid & require.
REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port overrun  output  1  one-cycle pulse: new byte lost because the holding register was full.

Function
REQ-011 BPS_CNT SHALL equal CLK_FREQ/UART_BPS (integer division); HALF_CNT SHALL equal BPS_CNT/2; counter width SHALL be clog2(BPS_CNT+1).
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all timing below refers to the synchronized signal rxd_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: a 1->0 transition of rxd_s SHALL move to START and clear the bit-period counter.
REQ-015 START: at counter == HALF_CNT, rxd_s==0 SHALL move to DATA with the counter cleared; rxd_s==1 SHALL return to IDLE (glitch reject, no output).
REQ-016 DATA: each time the counter reaches BPS_CNT, rxd_s SHALL be shifted into the shift register LSB-first and the counter cleared; after the 8th sample the FSM SHALL move to STOP.
REQ-017 STOP: at counter == BPS_CNT, rxd_s==1 SHALL deliver the byte; rxd_s==0 SHALL pulse frame_err for one cycle and discard the byte; both SHALL return to IDLE in that cycle (mid-stop), so the next start edge is accepted.
REQ-018 Delivery: data and valid SHALL update on the clock edge after the stop-bit sample (1-cycle latency).
REQ-019 valid SHALL stay 1 and data SHALL stay stable until a cycle with valid & require; valid SHALL then fall on the next edge unless a new byte is delivered in that same cycle.
REQ-020 Simultaneous accept and delivery: the new byte SHALL load, valid SHALL remain 1, no overrun.
REQ-021 Delivery while valid=1 and require=0: the new byte SHALL be dropped, the old byte kept, overrun pulsed for one cycle.
REQ-022 require SHALL have no effect while valid=0.
REQ-023 Bit-period counter SHALL count only outside IDLE and SHALL never exceed BPS_CNT.

Reset
REQ-024 While rst=1 at a clock edge: FSM IDLE, counter 0, shift register 0, synchronizer flops 1, data 8'h00, valid 0, frame_err 0, overrun 0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no output; after release, reception SHALL resume only on a fresh 1->0 edge.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state encoding, the clog2 function and the BPS_CNT/HALF_CNT derivation shared with the transmitter.
REQ-027 Synchronizer SHALL be the sub-module uart_sync_2ff; everything else SHALL stay in uart_rx.

Verification (CLK_FREQ=50_000_000, UART_BPS=115200: BPS_CNT=434, HALF_CNT=217)
REQ-028 Frame 0x A5 at 434 clk/bit, require=1 -> valid=1 with data=8'hA5 for exactly one cycle, no frame_err/overrun.
REQ-029 Low glitch of 100 clk on idle line -> return to IDLE, no valid, no frame_err.
REQ-030 Frame 0x3C with stop bit held low -> frame_err one-cycle pulse, valid stays 0.
REQ-031 Back-to-back 0x11, 0x22 with require=0 -> data=8'h11 held, overrun pulse at the second stop sample; require=1 then -> 0x11 accepted, valid falls.
REQ-032 Back-to-back 0x55, 0xAA with require=1 -> two deliveries, 0x55 then 0xAA, no overrun.
REQ-033 rst=1 pulse during bit 4 of a frame -> all outputs at reset values, no delivery; next clean frame 0x0F received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, bit-timing derivation and clog2.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned bps_cnt(input int unsigned clk_freq, input int unsigned bps);
    return clk_freq / bps;
  endfunction

  function automatic int unsigned half_cnt(input int unsigned clk_freq, input int unsigned bps);
    return bps_cnt(clk_freq, bps) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output handshake: byte + valid/require, plus error pulses.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       require;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    input  require
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    output require
  );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-byte holding register and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  uart_rx_if.master  rx_if
);

  localparam int unsigned BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned HALF_CNT = half_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned CNT_W    = clog2(BPS_CNT + 1);
  localparam logic [CNT_W-1:0] BPS_END  = CNT_W'(BPS_CNT);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CNT);

  logic             w_rxd_s;
  logic             r_rxd_prev;
  logic [1:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [2:0]       r_bit, w_bit_d;
  logic [7:0]       r_shift, w_shift_d;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_stop_hit;
  logic             w_deliver;
  logic             w_accept;
  logic             w_load;

  uart_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (uart_rxd),
    .o_q (w_rxd_s)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_cnt_d = '0;
        w_bit_d = '0;
        if (r_rxd_prev && !w_rxd_s) w_state_d = ST_START;
      end
      ST_START: begin
        if (r_cnt == HALF_END) begin
          w_cnt_d   = '0;
          // A line already high again at mid-start was a glitch.
          w_state_d = w_rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == BPS_END) begin
          w_cnt_d   = '0;
          w_shift_d = {w_rxd_s, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_d = ST_STOP;
          else               w_bit_d   = r_bit + 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_cnt == BPS_END) begin
          w_cnt_d   = '0;
          w_state_d = ST_IDLE;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign w_stop_hit = (r_state == ST_STOP) && (r_cnt == BPS_END);
  assign w_deliver  = w_stop_hit && w_rxd_s;
  assign w_accept   = r_valid && rx_if.require;
  // A delivery lands if the holder is empty or is being drained this cycle.
  assign w_load     = w_deliver && (!r_valid || w_accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rxd_prev  <= 1'b1;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bit       <= w_bit_d;
      r_shift     <= w_shift_d;
      r_rxd_prev  <= w_rxd_s;
      r_frame_err <= w_stop_hit && !w_rxd_s;
      r_overrun   <= w_deliver && r_valid && !rx_if.require;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.data      = r_data;
  assign rx_if.valid     = r_valid;
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.overrun   = r_overrun;

endmodule
